// File: rtl/adder_arb_pkg.sv
// Shared constants and helpers for the shared-adder arbiter slice.
// Requester IDs follow the pipeline's adder users.
package adder_arb_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned NUM_REQ_DEF = 3;
    localparam int unsigned ID_W_DEF    = 2;
    localparam int unsigned MAX_REQ     = 8;

    localparam int unsigned REQ_PC  = 0;
    localparam int unsigned REQ_BR  = 1;
    localparam int unsigned REQ_MEM = 2;

    // First set bit of vec at or after start, wrapping within n entries.
    // Returns start when nothing is set; callers qualify with |vec.
    function automatic logic [2:0] first_set_from(
        input logic [MAX_REQ-1:0] vec,
        input logic [2:0]         start,
        input int unsigned        n
    );
        logic [2:0] first;
        logic       found;
        logic [3:0] j;
        first = start;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = {1'b0, start} + 4'(k);
            if (j >= 4'(n)) j = j - 4'(n);
            if (k < n && !found && vec[j[2:0]]) begin
                first = j[2:0];
                found = 1'b1;
            end
        end
        return first;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: master = requesters + consumer,
// slave = the arbiter.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_sum;
    logic                      rsp_carry;
    logic [ID_W-1:0]           rsp_id;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy
    );
endinterface

// File: rtl/adder_arbiter_adder.sv
// Existing combinational adder shared by the pipeline's address generators.
module adder_arbiter_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/adder_arbiter.sv
// One registered adder shared by NUM_REQ valid/ready requesters, round-robin
// arbitration; ADDER_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);
    logic                can_accept;
    logic                take;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [DATA_W:0]     sum_wide;

    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_sum_q;
    logic                rsp_carry_q;
    logic [ID_W-1:0]     rsp_id_q;

    assign can_accept = !rsp_valid_q || bus.rsp_ready;
    assign take       = can_accept && (|bus.req_valid);
    assign grant_idx  = ID_W'(first_set_from(MAX_REQ'(bus.req_valid), 3'(ptr), NUM_REQ));

    always_comb begin
        bus.req_ready = '0;
        if (take) bus.req_ready[grant_idx] = 1'b1;
    end

    assign sel_a = bus.req_a[grant_idx*DATA_W +: DATA_W];
    assign sel_b = bus.req_b[grant_idx*DATA_W +: DATA_W];

    // Widened by one bit so the top sum bit is the carry-out.
    adder_arbiter_adder #(.WIDTH(DATA_W + 1)) u_adder (
        .a   ({1'b0, sel_a}),
        .b   ({1'b0, sel_b}),
        .sum (sum_wide)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
        end else if (take) begin
            rsp_valid_q <= 1'b1;
            rsp_sum_q   <= sum_wide[DATA_W-1:0];
            rsp_carry_q <= sum_wide[DATA_W];
            rsp_id_q    <= grant_idx;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = rsp_valid_q && !bus.rsp_ready;

endmodule
